// File: rtl/packet_snooper_pkg.sv
// Shared types and widths for the packet snooper write path.
// Stream word width is shared with the packet memory.
package packet_snooper_pkg;

  localparam int SNOOP_W = 64;
  localparam int KEEP_W  = SNOOP_W / 8;
  localparam int BCNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    DONE
  } state_e;

endpackage

// File: rtl/packet_snooper_keep_bytecount.sv
// Contiguous keep mask to byte count (0..8), combinational.
// Shared with the forwarder so both agree on packet lengths.
module packet_snooper_keep_bytecount
  import packet_snooper_pkg::*;
(
  input  logic [KEEP_W-1:0] keep,
  output logic [BCNT_W-1:0] bcnt
);

  always_comb begin
    bcnt = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      bcnt = bcnt + BCNT_W'(keep[i]);
    end
  end

endmodule

// File: rtl/packet_snooper.sv
// Ping/pong packet memory write-side snooper with done/ack handshake.
// Optional SNOOPER_DROP_CNT_EN adds a saturating overflow-packet counter.
module packet_snooper
  import packet_snooper_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [63:0]             snoop_data,
  input  logic [7:0]              snoop_keep,
  input  logic                    snoop_last,
  input  logic                    snoop_valid,
  output logic                    snoop_ready,
  input  logic                    buf_avail,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [63:0]             wr_data,
  output logic                    wr_en,
  output logic                    done,
  output logic [ADDR_WIDTH+3:0]   byte_len,
`ifdef SNOOPER_DROP_CNT_EN
  output logic [31:0]             drop_cnt,
`endif
  input  logic                    done_ack
);

  localparam int CW   = ADDR_WIDTH + 1;
  localparam int BL_W = ADDR_WIDTH + 4;
  localparam logic [CW-1:0] FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SNOOP_W-1:0]    wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;
  logic [BL_W-1:0]       byte_len_q, byte_len_d;
  logic [BCNT_W-1:0]     bcnt;
  logic                  accept;

  packet_snooper_keep_bytecount u_bytecount (
    .keep (snoop_keep),
    .bcnt (bcnt)
  );

  assign snoop_ready = (state_q == RECV) || (state_q == DROP);
  assign accept      = snoop_valid && snoop_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    done_d     = done_q;
    byte_len_d = byte_len_q;
    unique case (state_q)
      IDLE: begin
        if (buf_avail) state_d = RECV;
      end
      RECV: begin
        if (accept) begin
          // Buffer already full: this beat overflows the packet.
          if (cnt_q == FULL) begin
            if (snoop_last) cnt_d = '0;
            else            state_d = DROP;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
            wr_data_d = snoop_data;
            cnt_d     = cnt_q + CW'(1);
            if (snoop_last) begin
              byte_len_d = {1'b0, cnt_q[ADDR_WIDTH-1:0], 3'b000}
                         + BL_W'(bcnt);
              state_d    = DONE;
            end
          end
        end
      end
      DROP: begin
        if (accept && snoop_last) begin
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      DONE: begin
        if (done_q && done_ack) begin
          done_d  = 1'b0;
          cnt_d   = '0;
          state_d = buf_avail ? RECV : IDLE;
        end else begin
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      byte_len_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      byte_len_q <= byte_len_d;
    end
  end

  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign done     = done_q;
  assign byte_len = byte_len_q;

`ifdef SNOOPER_DROP_CNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (state_q == RECV && accept && cnt_q == FULL
        && drop_cnt_q != 32'hFFFF_FFFF) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_packet_snooper.sv
// Directed bench for packet_snooper (ADDR_WIDTH=3).
// Table-driven handshake rows plus hand-written overflow/reset/back-to-back runs.
module tb_packet_snooper;

  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   snoop_data = '0;
  logic [7:0]    snoop_keep = '0;
  logic          snoop_last = 1'b0;
  logic          snoop_valid = 1'b0;
  logic          snoop_ready;
  logic          buf_avail = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [63:0]   wr_data;
  logic          wr_en;
  logic          done;
  logic [AW+3:0] byte_len;
  logic          done_ack = 1'b0;
`ifdef SNOOPER_DROP_CNT_EN
  logic [31:0]   drop_cnt;
`endif

  packet_snooper #(.ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .snoop_data  (snoop_data),
    .snoop_keep  (snoop_keep),
    .snoop_last  (snoop_last),
    .snoop_valid (snoop_valid),
    .snoop_ready (snoop_ready),
    .buf_avail   (buf_avail),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .done        (done),
    .byte_len    (byte_len),
`ifdef SNOOPER_DROP_CNT_EN
    .drop_cnt    (drop_cnt),
`endif
    .done_ack    (done_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [AW-1:0] q_addr[$];
  logic [63:0]   q_data[$];
  int            done_rises = 0;
  logic          done_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
    if (done === 1'b1 && !done_prev) done_rises++;
    done_prev <= (done === 1'b1);
  end

  task automatic clr_log();
    q_addr.delete();
    q_data.delete();
    done_rises = 0;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [63:0] d, input logic [7:0] k,
                      input logic l);
    int n;
    n = 0;
    snoop_valid = 1'b1;
    snoop_data  = d;
    snoop_keep  = k;
    snoop_last  = l;
    @(negedge clk);
    while (!snoop_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!snoop_ready) chk("beat_ready_timeout", 64'(snoop_ready), 64'd1);
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
    snoop_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_len);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, 64'(done), 64'd1);
    chk({name, "_len"}, 64'(byte_len), 64'(exp_len));
    chk({name, "_ready_in_done"}, 64'(snoop_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    done_ack = 1'b1;
    @(posedge clk);
    #1;
    done_ack = 1'b0;
  endtask

  typedef struct {
    logic        avail;
    logic        valid;
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        ack;
    logic        e_ready;
    logic        e_wen;
    logic [2:0]  e_addr;
    logic [63:0] e_data;
    logic        e_done;
    logic [6:0]  e_len;
  } vec_t;

  vec_t vt[19];

  initial begin
    // test 1: 3-beat packet, keep 0xF0 -> 20 bytes
    vt[0]  = '{1,0,64'h0,8'h00,0,0, 0,0,0,64'h0,0,0};
    vt[1]  = '{1,1,64'hD0,8'hFF,0,0, 1,0,0,64'h0,0,0};
    vt[2]  = '{1,1,64'hD1,8'hFF,0,0, 1,1,0,64'hD0,0,0};
    vt[3]  = '{1,1,64'hD2,8'hF0,1,0, 1,1,1,64'hD1,0,0};
    vt[4]  = '{0,0,64'h0,8'h00,0,0, 0,1,2,64'hD2,0,0};
    vt[5]  = '{0,0,64'h0,8'h00,0,0, 0,0,0,64'h0,1,20};
    vt[6]  = '{0,0,64'h0,8'h00,0,0, 0,0,0,64'h0,1,20};
    vt[7]  = '{0,0,64'h0,8'h00,0,1, 0,0,0,64'h0,1,20};
    vt[8]  = '{0,0,64'h0,8'h00,0,0, 0,0,0,64'h0,0,0};
    // test 2: no grant -> no ready; grant -> written at addr 0
    vt[9]  = '{0,1,64'hEE,8'h80,1,0, 0,0,0,64'h0,0,0};
    vt[10] = '{0,1,64'hEE,8'h80,1,0, 0,0,0,64'h0,0,0};
    vt[11] = '{0,1,64'hEE,8'h80,1,0, 0,0,0,64'h0,0,0};
    vt[12] = '{0,1,64'hEE,8'h80,1,0, 0,0,0,64'h0,0,0};
    vt[13] = '{0,1,64'hEE,8'h80,1,0, 0,0,0,64'h0,0,0};
    vt[14] = '{1,1,64'hE9,8'hFF,0,0, 0,0,0,64'h0,0,0};
    vt[15] = '{1,1,64'hE1,8'h80,1,0, 1,0,0,64'h0,0,0};
    vt[16] = '{0,0,64'h0,8'h00,0,0, 0,1,0,64'hE1,0,0};
    vt[17] = '{0,0,64'h0,8'h00,0,1, 0,0,0,64'h0,1,1};
    vt[18] = '{0,0,64'h0,8'h00,0,0, 0,0,0,64'h0,0,0};

    #3;
    chk("rst_ready", 64'(snoop_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_byte_len", 64'(byte_len), 64'd0);
`ifdef SNOOPER_DROP_CNT_EN
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
    idle_cyc(2);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      buf_avail   = vt[i].avail;
      snoop_valid = vt[i].valid;
      snoop_data  = vt[i].data;
      snoop_keep  = vt[i].keep;
      snoop_last  = vt[i].last;
      done_ack    = vt[i].ack;
      @(negedge clk);
      chk($sformatf("row%0d_ready", i), 64'(snoop_ready),
          64'(vt[i].e_ready));
      chk($sformatf("row%0d_wr_en", i), 64'(wr_en), 64'(vt[i].e_wen));
      chk($sformatf("row%0d_done", i), 64'(done), 64'(vt[i].e_done));
      if (vt[i].e_wen) begin
        chk($sformatf("row%0d_addr", i), 64'(wr_addr), 64'(vt[i].e_addr));
        chk($sformatf("row%0d_data", i), wr_data, vt[i].e_data);
      end
      if (vt[i].e_done)
        chk($sformatf("row%0d_len", i), 64'(byte_len), 64'(vt[i].e_len));
      @(posedge clk);
      #1;
    end
    snoop_valid = 1'b0;
    done_ack    = 1'b0;

    // test 3: overflowing packets, then a good 2-beat packet
    buf_avail = 1'b1;
    clr_log();
    for (int i = 0; i < 9; i++)
      beat(64'h300 + 64'(i), 8'hFF, i == 8);
    idle_cyc(2);
    chk("ovf9_no_done", 64'(done_rises), 64'd0);
    chk("ovf9_writes", 64'(q_addr.size()), 64'd8);
`ifdef SNOOPER_DROP_CNT_EN
    chk("ovf9_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
    for (int i = 0; i < 11; i++)
      beat(64'h400 + 64'(i), 8'hFF, i == 10);
    idle_cyc(2);
    chk("ovf11_no_done", 64'(done_rises), 64'd0);
    chk("ovf11_writes", 64'(q_addr.size()), 64'd16);
    if (q_addr.size() >= 9) begin
      chk("ovf11_first_addr", 64'(q_addr[8]), 64'd0);
      chk("ovf11_first_data", q_data[8], 64'h400);
    end
`ifdef SNOOPER_DROP_CNT_EN
    chk("ovf11_drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    beat(64'h500, 8'hFF, 1'b0);
    beat(64'h501, 8'hFF, 1'b1);
    wait_done("after_ovf", 16);
    ack();
    chk("after_ovf_writes", 64'(q_addr.size()), 64'd18);
    chk("after_ovf_done_cnt", 64'(done_rises), 64'd1);
    if (q_addr.size() == 18) begin
      chk("after_ovf_a0", 64'(q_addr[16]), 64'd0);
      chk("after_ovf_d0", q_data[16], 64'h500);
      chk("after_ovf_a1", 64'(q_addr[17]), 64'd1);
      chk("after_ovf_d1", q_data[17], 64'h501);
    end

    // test 4: exactly full buffer
    clr_log();
    for (int i = 0; i < 8; i++)
      beat(64'h600 + 64'(i), 8'hFF, i == 7);
    wait_done("full", 64);
    ack();
    chk("full_writes", 64'(q_addr.size()), 64'd8);
    for (int i = 0; i < 8 && i < q_addr.size(); i++) begin
      chk($sformatf("full_a%0d", i), 64'(q_addr[i]), 64'(i));
      chk($sformatf("full_d%0d", i), q_data[i], 64'h600 + 64'(i));
    end
`ifdef SNOOPER_DROP_CNT_EN
    chk("full_drop_cnt", 64'(drop_cnt), 64'd2);
`endif

    // test 5: asynchronous reset mid-packet
    beat(64'h700, 8'hFF, 1'b0);
    beat(64'h701, 8'hFF, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", 64'(snoop_ready), 64'd0);
    chk("arst_wr_en", 64'(wr_en), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    #1 rst = 1'b0;
    clr_log();
    beat(64'h710, 8'hC0, 1'b1);
    wait_done("arst_pkt", 2);
    ack();
    chk("arst_writes", 64'(q_addr.size()), 64'd1);
    if (q_addr.size() == 1) begin
      chk("arst_a0", 64'(q_addr[0]), 64'd0);
      chk("arst_d0", q_data[0], 64'h710);
    end

    // test 6: back-to-back packets with gaps, grant held
    clr_log();
    beat(64'hA0, 8'hFF, 1'b0);
    idle_cyc(2);
    beat(64'hA1, 8'hFE, 1'b1);
    wait_done("b2b_a", 15);
    @(negedge clk);
    chk("b2b_hold_ready", 64'(snoop_ready), 64'd0);
    chk("b2b_hold_done", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    ack();
    @(negedge clk);
    chk("b2b_ack_ready", 64'(snoop_ready), 64'd1);
    chk("b2b_ack_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    beat(64'hB0, 8'hFF, 1'b0);
    idle_cyc(1);
    beat(64'hB1, 8'hFF, 1'b0);
    idle_cyc(3);
    beat(64'hB2, 8'h00, 1'b1);
    wait_done("b2b_b", 16);
    ack();
    chk("b2b_writes", 64'(q_addr.size()), 64'd5);
    if (q_addr.size() == 5) begin
      chk("b2b_a1", 64'(q_addr[1]), 64'd1);
      chk("b2b_a2", 64'(q_addr[2]), 64'd0);
      chk("b2b_d2", q_data[2], 64'hB0);
      chk("b2b_a4", 64'(q_addr[4]), 64'd2);
      chk("b2b_d4", q_data[4], 64'hB2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
